pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and NOP bubbles
// Optional performance counters (stall_cnt, bubble_cnt) are built only when PIPE_STAGE_PERF_EN is defined.
// in_ready comes straight from a flop (!skid_valid), so there is no combinational ready path through the stage.

module pipe_stage_reg #(
   parameter int              DATA_W = 160,
   parameter int              OP_W   = 6,
   parameter logic [OP_W-1:0] NOP_OP = 6'b110111,
   parameter int              CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rstd,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   // Reject nonsensical widths at elaboration time.
   if (DATA_W < 1 || OP_W < 1 || CNT_W < 1) begin : g_param_check
      $error("pipe_stage_reg: DATA_W, OP_W and CNT_W must be at least 1");
   end

   // Main entry feeds the outputs; skid entry absorbs the one extra beat
   // that arrives while in_ready is still high from the previous cycle.
   logic              main_valid;
   logic [OP_W-1:0]   main_op;
   logic [DATA_W-1:0] main_data;
   logic              skid_valid;
   logic [OP_W-1:0]   skid_op;
   logic [DATA_W-1:0] skid_data;

   logic accept;
   logic pop;

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_op    = main_valid ? main_op : NOP_OP;
   assign out_data  = main_data;

   assign accept = in_valid && in_ready;
   assign pop    = main_valid && out_ready;

   // Main/skid update: flush kills everything, otherwise refill main from skid first, then from the input.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         main_valid <= 1'b0;
         main_op    <= NOP_OP;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_op    <= NOP_OP;
         skid_data  <= '0;
      end else if (flush) begin
         // A pop in this cycle has already been seen downstream; any accept is dropped.
         main_valid <= 1'b0;
         main_op    <= NOP_OP;
         skid_valid <= 1'b0;
         skid_op    <= NOP_OP;
      end else if (!main_valid || pop) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_op    <= skid_op;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            skid_op    <= NOP_OP;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_op    <= in_op;
            main_data  <= in_data;
         end else begin
            // Payload is left as-is so the data bus does not toggle on bubbles.
            main_valid <= 1'b0;
            main_op    <= NOP_OP;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_op    <= in_op;
         skid_data  <= in_data;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating stall/bubble counters; only reset clears them, flush does not.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (!main_valid && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
